// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: turns the system clock into single-cycle game tick enables,
// owns the IDLE/RUN/PAUSE/OVER game state and shortens the tick period as levels rise.
// Ports: clock_in/reset (async, active-high); start, pause_toggle, crash controls;
// tick, level, score, state, game_over outputs.
module game_tick_scheduler #(
  parameter logic [27:0] BASE_DIVISOR    = 28'd20000000,
  parameter logic [27:0] STEP            = 28'd1000000,
  parameter logic [27:0] MIN_DIVISOR     = 28'd5000000,
  parameter int          TICKS_PER_LEVEL = 100,
  parameter int          MAX_LEVEL       = 15
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        start,
  input  logic        pause_toggle,
  input  logic        crash,
  output logic        tick,
  output logic [3:0]  level,
  output logic [15:0] score,
  output logic [1:0]  state,
  output logic        game_over
);

  localparam int LCW = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
  localparam logic [LCW-1:0] LVL_LAST = LCW'(TICKS_PER_LEVEL - 1);
  localparam logic [3:0]     LVL_MAX  = 4'(MAX_LEVEL);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t           cur_state, nxt_state;
  logic [27:0]      counter;
  logic [27:0]      period;
  logic [LCW-1:0]   lvl_cnt;
  logic             do_clear;   // start accepted: reset game counters
  logic             do_count;   // RUN cycle with no crash/pause: advance counter
  logic             wrap;       // interval complete this cycle
  logic             lvl_wrap;   // interval completes a level's worth of ticks
  logic [3:0]       level_nxt;

  // Clamp in 32 bits so a large level*STEP can never underflow the subtraction.
  function automatic logic [27:0] period_for(input logic [3:0] lv);
    logic [31:0] prod;
    logic [31:0] span;
    prod = 32'(lv) * 32'(STEP);
    span = 32'(BASE_DIVISOR) - 32'(MIN_DIVISOR);
    if (prod >= span)
      period_for = MIN_DIVISOR;
    else
      period_for = 28'(32'(BASE_DIVISOR) - prod);
  endfunction

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset)
      cur_state <= IDLE;
    else
      cur_state <= nxt_state;
  end

  // Priority crash > pause_toggle > start; lower-priority inputs are dropped.
  always_comb begin
    nxt_state = cur_state;
    do_clear  = 1'b0;
    do_count  = 1'b0;
    case (cur_state)
      IDLE: begin
        if (start) begin
          nxt_state = RUN;
          do_clear  = 1'b1;
        end
      end
      RUN: begin
        if (crash)
          nxt_state = OVER;
        else if (pause_toggle)
          nxt_state = PAUSE;
        else
          do_count = 1'b1;
      end
      PAUSE: begin
        if (crash)
          nxt_state = OVER;
        else if (pause_toggle)
          nxt_state = RUN;
      end
      OVER: begin
        if (start) begin
          nxt_state = RUN;
          do_clear  = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign wrap      = do_count && (counter == period - 28'd1);
  assign lvl_wrap  = wrap && (lvl_cnt == LVL_LAST);
  assign level_nxt = (lvl_wrap && (level < LVL_MAX)) ? level + 4'd1 : level;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      tick    <= 1'b0;
      level   <= 4'd0;
      score   <= 16'd0;
      counter <= 28'd0;
      lvl_cnt <= '0;
      period  <= BASE_DIVISOR;
    end else begin
      tick <= wrap;
      if (do_clear) begin
        counter <= 28'd0;
        score   <= 16'd0;
        level   <= 4'd0;
        lvl_cnt <= '0;
        period  <= BASE_DIVISOR;
      end else if (do_count) begin
        if (wrap) begin
          counter <= 28'd0;
          if (score != 16'hFFFF)
            score <= score + 16'd1;
          lvl_cnt <= lvl_wrap ? '0 : lvl_cnt + LCW'(1);
          level   <= level_nxt;
          // Only loaded at a wrap, so a running interval is never shortened.
          period  <= period_for(level_nxt);
        end else begin
          counter <= counter + 28'd1;
        end
      end
    end
  end

  assign state     = cur_state;
  assign game_over = (cur_state == OVER);

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: directed bench for game_tick_scheduler with small divisors.
// Covers reset, level-up spacing, period floor, crash, pause and mid-run reset.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_game_tick_scheduler;

  logic        clock_in;
  logic        reset;
  logic        start;
  logic        pause_toggle;
  logic        crash;
  logic        tick;
  logic [3:0]  level;
  logic [15:0] score;
  logic [1:0]  state;
  logic        game_over;

  int n_checks = 0;
  int n_pass   = 0;
  int elapsed  = 0;
  int tick_seen = 0;

  game_tick_scheduler #(
    .BASE_DIVISOR    (28'd10),
    .STEP            (28'd2),
    .MIN_DIVISOR     (28'd4),
    .TICKS_PER_LEVEL (3),
    .MAX_LEVEL       (15)
  ) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .start        (start),
    .pause_toggle (pause_toggle),
    .crash        (crash),
    .tick         (tick),
    .level        (level),
    .score        (score),
    .state        (state),
    .game_over    (game_over)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clock_in);
      elapsed++;
      if (tick) tick_seen++;
    end
  endtask

  // Cycles from the current falling edge until tick is seen high; -1 on timeout.
  task automatic wait_tick(output int n);
    bit got;
    got = 0;
    n = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock_in);
      n++;
      if (tick) got = 1;
    end
    if (!got) n = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_toggle = 1'b1;
    step(1);
    pause_toggle = 1'b0;
  endtask

  initial begin
    int n;
    int lv;
    int per;

    reset = 1'b1;
    start = 1'b0;
    pause_toggle = 1'b0;
    crash = 1'b0;

    // Reset applied before any clock edge.
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_score", 32'(score), 0);
    check("rst_level", 32'(level), 0);
    check("rst_game_over", 32'(game_over), 0);

    @(negedge clock_in);
    reset = 1'b0;
    tick_seen = 0;
    pulse_pause();
    crash = 1'b1;
    step(1);
    crash = 1'b0;
    step(12);
    check("idle_state", 32'(state), 0);
    check("idle_no_ticks", 32'(tick_seen), 0);

    // Level-up and period floor: gap = max(10 - 2*level, 4).
    pulse_start();
    check("start_state", 32'(state), 1);
    for (int i = 1; i <= 15; i++) begin
      lv  = (i - 1) / 3;
      per = 10 - 2 * lv;
      if (per < 4) per = 4;
      wait_tick(n);
      check($sformatf("gap%0d", i), 32'(n), 32'(per));
      check($sformatf("score%0d", i), 32'(score), 32'(i));
      check($sformatf("level%0d", i), 32'(level), 32'(i / 3));
    end

    // Crash (with start) on the edge where counter == period-1 (period 4).
    step(3);
    crash = 1'b1;
    start = 1'b1;
    step(1);
    crash = 1'b0;
    start = 1'b0;
    check("crash_tick", 32'(tick), 0);
    check("crash_score", 32'(score), 15);
    check("crash_level", 32'(level), 5);
    check("crash_state", 32'(state), 3);
    check("crash_game_over", 32'(game_over), 1);
    tick_seen = 0;
    step(12);
    check("over_no_ticks", 32'(tick_seen), 0);
    check("over_state", 32'(state), 3);

    // Restart from OVER.
    pulse_start();
    check("restart_state", 32'(state), 1);
    check("restart_score", 32'(score), 0);
    check("restart_level", 32'(level), 0);
    check("restart_game_over", 32'(game_over), 0);
    wait_tick(n);
    check("restart_gap", 32'(n), 10);
    check("restart_score1", 32'(score), 1);

    // Pause 4 cycles after a tick; 21 held edges delay the tick to 31 cycles.
    elapsed = 0;
    tick_seen = 0;
    step(3);
    pulse_pause();
    check("pause_state", 32'(state), 2);
    step(19);
    pulse_pause();
    check("resume_state", 32'(state), 1);
    check("pause_no_ticks", 32'(tick_seen), 0);
    check("pause_score", 32'(score), 1);
    wait_tick(n);
    check("pause_gap", (n < 0) ? 32'hFFFF_FFFF : 32'(elapsed + n), 31);

    // Climb to level 2: gaps 10, 8, 8, 8.
    wait_tick(n);
    check("l2_gap_a", 32'(n), 10);
    check("l2_level_a", 32'(level), 1);
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      check($sformatf("l2_gap_%0d", i), 32'(n), 8);
    end
    check("l2_level", 32'(level), 2);
    check("l2_score", 32'(score), 6);

    // Reset mid-interval, between clock edges.
    step(3);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_state", 32'(state), 0);
    check("mrst_level", 32'(level), 0);
    check("mrst_score", 32'(score), 0);
    check("mrst_tick", 32'(tick), 0);
    check("mrst_game_over", 32'(game_over), 0);
    @(negedge clock_in);
    reset = 1'b0;
    tick_seen = 0;
    step(15);
    check("mrst_no_ticks", 32'(tick_seen), 0);
    check("mrst_idle", 32'(state), 0);
    pulse_start();
    wait_tick(n);
    check("mrst_first_gap", 32'(n), 10);
    check("mrst_score1", 32'(score), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
